data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store at a
// time, big-endian byte lanes, fixed response latency, registered results.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          bad;
    logic [4:0]    sh;
    logic [31:0]   word_rd;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic          unused_addr_hi;

    // Misaligned half/word or the reserved size code is an error.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] o);
        logic e;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = o[0];
            SZ_WORD: e = |o;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Right-shift that brings the addressed big-endian lane down to bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] o);
        logic [4:0] s;
        case (size)
            SZ_BYTE: s = {~o, 3'b000};
            SZ_HALF: s = {~o[1], 4'b0000};
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    // Bits of the word touched by a store of this size/offset.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [4:0] s);
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = 32'h0000_00FF << s;
            SZ_HALF: m = 32'h0000_FFFF << s;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Pull the addressed lane out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [4:0] s, input logic sgn);
        logic [31:0] t;
        logic [31:0] r;
        t = w >> s;
        case (size)
            SZ_BYTE: r = {{24{sgn & t[7]}}, t[7:0]};
            SZ_HALF: r = {{16{sgn & t[15]}}, t[15:0]};
            SZ_WORD: r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign idx            = req_addr[AW+1:2];
    assign off            = req_addr[1:0];
    assign bad            = access_err(req_size, off);
    assign sh             = lane_shift(req_size, off);
    assign word_rd        = mem[idx];
    assign wr_mask        = lane_mask(req_size, sh);
    assign wr_data        = req_wdata << sh;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign stall      = (state_q == BUSY) || ((state_q == IDLE) && req_valid);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state, latency countdown and result capture at acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                    err_d   = bad;
                    rdata_d = (bad || req_we) ? 32'd0
                                              : load_extract(word_rd, req_size, sh, req_signed);
                    wr_en   = req_we && !bad;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: lane-masked write on the accepting edge, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= (mem[idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset/handshake
// sequences, and random traffic against a byte-array reference model.
module tb_data_mem_responder;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        v1;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;
    logic        rdy1, rv1, re1, st1;
    logic [31:0] rd1;

    logic        sel;
    logic        o_ready, o_valid, o_err, o_stall;
    logic [31:0] o_rdata;

    int checks;
    int failures;

    logic [7:0] mm [4096];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_valid(v1), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(re1), .stall(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_ready = sel ? rdy1 : req_ready;
        o_valid = sel ? rv1  : resp_valid;
        o_err   = sel ? re1  : resp_err;
        o_stall = sel ? st1  : stall;
        o_rdata = sel ? rd1  : resp_rdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference: memory as a flat big-endian byte array, addresses mod 4 KiB.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int n;
        int a;
        logic [31:0] v;
        er = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        rd = 32'd0;
        if (er) return;
        n = 1 << size;
        a = int'(addr % 32'd4096);
        if (we) begin
            for (int i = 0; i < n; i++) mm[a + i] = 8'(wdata >> (8 * (n - 1 - i)));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mm[a + i]};
            if (n < 4 && sgn && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.nm = nm;
        tbl.push_back(v);
    endtask

    // One full transaction on the selected instance; starts and ends in IDLE just after an edge.
    task automatic do_req(input logic s, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int lat;
        int lexp;
        lexp = s ? 1 : 2;
        sel = s;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        if (s) v1 = 1'b1; else req_valid = 1'b1;
        #1;
        chk1({nm, " ready_idle"}, o_ready, 1'b1);
        chk1({nm, " stall_req"}, o_stall, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; v1 = 1'b0;
        req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!o_valid && lat < 20) begin
            chk1({nm, " stall_busy"}, o_stall, 1'b1);
            chk1({nm, " ready_busy"}, o_ready, 1'b0);
            if (s) v1 = 1'($urandom_range(0, 1)); else req_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(lexp));
        chk({nm, " rdata"}, o_rdata, exp_rd);
        chk1({nm, " err"}, o_err, exp_err);
        chk1({nm, " stall_resp"}, o_stall, 1'b0);
        chk1({nm, " ready_resp"}, o_ready, 1'b0);
        req_valid = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;
        chk1({nm, " valid_pulse"}, o_valid, 1'b0);
        chk({nm, " rdata_hold"}, o_rdata, exp_rd);
        chk1({nm, " ready_after"}, o_ready, 1'b1);
    endtask

    // Continuous req_valid: IDLE at phase 0, RESP at phase L, BUSY otherwise.
    task automatic handshake(input logic s, input int lexp);
        int pulses;
        int phase;
        sel = s;
        pulses = 0;
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'd0;
        if (s) v1 = 1'b1; else req_valid = 1'b1;
        #1;
        for (int k = 0; k < 4 * (lexp + 1); k++) begin
            phase = k % (lexp + 1);
            chk1("hs ready", o_ready, phase == 0);
            chk1("hs stall", o_stall, phase != lexp);
            chk1("hs valid", o_valid, phase == lexp);
            if (o_valid) pulses++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; v1 = 1'b0;
        chk("hs responses", 32'(pulses), 32'd4);
        @(posedge clk); #1;
    endtask

    logic [31:0] erd;
    logic        eer;
    logic        rwe;
    logic [1:0]  rsz;
    logic        rsg;
    logic [31:0] rad;
    logic [31:0] rwd;

    initial begin
        checks = 0; failures = 0;
        sel = 1'b0;
        rstn = 1'b0;
        req_valid = 1'b0; v1 = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // Reset state.
        #3;
        chk1("rst valid", resp_valid, 1'b0);
        chk1("rst err", resp_err, 1'b0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk1("rst ready", req_ready, 1'b1);
        chk1("rst stall_idle", stall, 1'b0);
        req_valid = 1'b1; #1;
        chk1("rst stall_follow", stall, 1'b1);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        add(1, 2'd2, 0, 32'h40, 32'h1234_5678, 32'h0, 0, "st_w40");
        add(0, 2'd2, 0, 32'h40, 32'h0, 32'h1234_5678, 0, "ld_w40");
        add(1, 2'd2, 0, 32'h10, 32'h80FF_7F01, 32'h0, 0, "st_w10");
        add(0, 2'd0, 1, 32'h10, 32'h0, 32'hFFFF_FF80, 0, "ld_sb10");
        add(0, 2'd0, 0, 32'h13, 32'h0, 32'h0000_0001, 0, "ld_ub13");
        add(0, 2'd1, 1, 32'h12, 32'h0, 32'h0000_7F01, 0, "ld_sh12");
        add(0, 2'd1, 1, 32'h10, 32'h0, 32'hFFFF_80FF, 0, "ld_sh10");
        add(0, 2'd0, 0, 32'h11, 32'h0, 32'h0000_00FF, 0, "ld_ub11");
        add(1, 2'd0, 0, 32'h11, 32'hFFFF_FFAB, 32'h0, 0, "st_b11");
        add(0, 2'd2, 0, 32'h10, 32'h0, 32'h80AB_7F01, 0, "ld_w10_part");
        add(1, 2'd2, 0, 32'h42, 32'hDEAD_BEEF, 32'h0, 1, "st_w42_mis");
        add(0, 2'd3, 1, 32'h40, 32'h0, 32'h0, 1, "ld_sz3");
        add(0, 2'd2, 0, 32'h40, 32'h0, 32'h1234_5678, 0, "ld_w40_keep");
        add(0, 2'd1, 0, 32'h41, 32'h0, 32'h0, 1, "ld_h41_mis");
        add(1, 2'd1, 0, 32'h13, 32'h5555_5555, 32'h0, 1, "st_h13_mis");
        add(1, 2'd1, 0, 32'h12, 32'hFFFF_1234, 32'h0, 0, "st_h12");
        add(0, 2'd2, 0, 32'h10, 32'h0, 32'h80AB_1234, 0, "ld_w10_half");
        add(1, 2'd2, 0, 32'h1000, 32'hCAFE_F00D, 32'h0, 0, "st_wrap");
        add(0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, "ld_wrap0");
        add(0, 2'd2, 0, 32'hFFFF_F040, 32'h0, 32'h1234_5678, 0, "ld_hi_ign");
        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, erd, eer);
            do_req(1'b0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_rd, tbl[i].exp_err, tbl[i].nm);
        end

        // Reset while a load is in BUSY: no response, outputs cleared at once.
        sel = 1'b0;
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk1("abort busy", req_ready, 1'b0);
        rstn = 1'b0; #1;
        chk1("abort ready", req_ready, 1'b1);
        chk1("abort valid", resp_valid, 1'b0);
        chk("abort rdata", resp_rdata, 32'd0);
        chk1("abort stall", stall, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk1("abort valid_rst", resp_valid, 1'b0);
        end
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk1("abort valid_after", resp_valid, 1'b0);
            chk1("abort ready_after", req_ready, 1'b1);
        end

        // Reset after a store was accepted: the write stays.
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'h5A5A_A5A5;
        req_valid = 1'b1;
        model(1'b1, 2'd2, 1'b0, 32'h80, 32'h5A5A_A5A5, erd, eer);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk1("abort_st valid", resp_valid, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h5A5A_A5A5, 1'b0, "ld_after_abort");

        // Random traffic against the model, over a fully initialised 64-byte window.
        for (int w = 0; w < 16; w++) begin
            rwd = $urandom;
            model(1'b1, 2'd2, 1'b0, 32'(w * 4), rwd, erd, eer);
            do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), rwd, erd, eer, "init");
        end
        for (int k = 0; k < 200; k++) begin
            rwe = 1'($urandom_range(0, 1));
            rsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rsg = 1'($urandom_range(0, 1));
            rad = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            rwd = $urandom;
            model(rwe, rsz, rsg, rad, rwd, erd, eer);
            do_req(1'b0, rwe, rsz, rsg, rad, rwd, erd, eer, "rand");
        end

        // Back-to-back handshake with req_valid held high, both latencies.
        handshake(1'b0, 2);
        handshake(1'b1, 1);

        // LATENCY=1, 64-word instance.
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 1'b0, "l1 st_w40");
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0, "l1 ld_w40");
        do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 32'h0000_0012, 1'b0, "l1 ld_sb40");
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0BAD_F00D, 32'h0, 1'b0, "l1 st_wrap");
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "l1 ld_wrap0");
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, "l1 ld_mis");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
